// File: rtl/piso_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piso_pkg : shared state type and counter-width helper for the PISO/SIPO pair
// Rev 1.0
// ---------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piso_bit_counter : loadable down-counter that saturates at zero
// Rev 1.0
// ---------------------------------------------------------------------------
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [cnt_w(WIDTH)-1:0]   load_val,
  input  logic                      dec,
  output logic [cnt_w(WIDTH)-1:0]   cnt,
  output logic                      is_zero
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piso_serializer : parallel-in serial-out transmitter with valid/ready on both sides
// Rev 1.0
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic             so_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [WIDTH-1:0] sreg_shift;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             accept;
  logic             beat;

  assign so_valid = (state_q == SHIFT);
  assign busy     = (state_q == SHIFT);
  assign so_last  = so_valid && cnt_zero;
  assign beat     = so_valid && so_ready;
  // Ready also on the final beat so a queued word follows with no idle cycle.
  assign pi_ready = (state_q == IDLE) || (beat && so_last);
  assign accept   = pi_valid && pi_ready;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
      assign so         = sreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
      assign so         = sreg_q[0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = pi_data;
    end else if (beat) begin
      sreg_d = sreg_shift;
      if (so_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CW'(WIDTH - 1)),
    .dec      (beat),
    .cnt      (cnt),
    .is_zero  (cnt_zero)
  );

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_piso_serializer : directed vector bench for MSB-first and LSB-first instances
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  typedef struct {
    logic       pv;
    logic [3:0] pd;
    logic       sr;
    logic       e_sv;
    logic       e_so_m;
    logic       e_so_l;
    logic       e_last;
    logic       e_pr;
    logic       e_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pi_data = 4'h0;
  logic       pi_valid = 1'b0;
  logic       so_ready = 1'b1;

  logic pr_m, so_m, sv_m, last_m, busy_m;
  logic pr_l, so_l, sv_l, last_l, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_valid(pi_valid), .pi_ready(pr_m),
    .so_ready(so_ready), .so(so_m), .so_valid(sv_m), .so_last(last_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .pi_data(pi_data), .pi_valid(pi_valid), .pi_ready(pr_l),
    .so_ready(so_ready), .so(so_l), .so_valid(sv_l), .so_last(last_l), .busy(busy_l)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pv, input logic [3:0] pd, input logic sr,
                              input logic sv, input logic som, input logic sol,
                              input logic last, input logic pr, input logic bsy);
    vec_t v;
    v.pv = pv; v.pd = pd; v.sr = sr;
    v.e_sv = sv; v.e_so_m = som; v.e_so_l = sol;
    v.e_last = last; v.e_pr = pr; v.e_busy = bsy;
    return v;
  endfunction

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step(input vec_t v, input int idx);
    @(posedge clk);
    #2;
    pi_valid = v.pv;
    pi_data  = v.pd;
    so_ready = v.sr;
    #1;
    chk($sformatf("v%0d so_valid", idx), sv_m,   v.e_sv);
    chk($sformatf("v%0d so_msb",   idx), so_m,   v.e_so_m);
    chk($sformatf("v%0d so_lsb",   idx), so_l,   v.e_so_l);
    chk($sformatf("v%0d so_last",  idx), last_m, v.e_last);
    chk($sformatf("v%0d pi_ready", idx), pr_m,   v.e_pr);
    chk($sformatf("v%0d busy",     idx), busy_m, v.e_busy);
    chk($sformatf("v%0d lsb_valid", idx), sv_l,  v.e_sv);
    chk($sformatf("v%0d lsb_last", idx), last_l, v.e_last);
    chk($sformatf("v%0d lsb_ready", idx), pr_l,  v.e_pr);
  endtask

  vec_t vecs[27];
  vec_t post[6];

  initial begin
    //                pv  pd    sr  sv  som sol last pr  busy
    // 4'b1011 single word
    vecs[0]  = mk(1, 4'hB, 1,  0,  0,  0,  0,  1,  0);
    vecs[1]  = mk(0, 4'h0, 1,  1,  1,  1,  0,  0,  1);
    vecs[2]  = mk(0, 4'h0, 1,  1,  0,  1,  0,  0,  1);
    vecs[3]  = mk(0, 4'h0, 1,  1,  1,  0,  0,  0,  1);
    vecs[4]  = mk(0, 4'h0, 1,  1,  1,  1,  1,  1,  1);
    vecs[5]  = mk(0, 4'h7, 1,  0,  0,  0,  0,  1,  0);
    // back-to-back 4'hA then 4'h5
    vecs[6]  = mk(1, 4'hA, 1,  0,  0,  0,  0,  1,  0);
    vecs[7]  = mk(1, 4'h5, 1,  1,  1,  0,  0,  0,  1);
    vecs[8]  = mk(1, 4'h5, 1,  1,  0,  1,  0,  0,  1);
    vecs[9]  = mk(1, 4'h5, 1,  1,  1,  0,  0,  0,  1);
    vecs[10] = mk(1, 4'h5, 1,  1,  0,  1,  1,  1,  1);
    vecs[11] = mk(0, 4'h0, 1,  1,  0,  1,  0,  0,  1);
    vecs[12] = mk(0, 4'h0, 1,  1,  1,  0,  0,  0,  1);
    vecs[13] = mk(0, 4'h0, 1,  1,  0,  1,  0,  0,  1);
    vecs[14] = mk(0, 4'h0, 1,  1,  1,  0,  1,  1,  1);
    vecs[15] = mk(0, 4'h0, 1,  0,  0,  0,  0,  1,  0);
    // 4'b0110 with a 2-cycle stall on bit 2 and a 1-cycle stall on the last bit
    vecs[16] = mk(1, 4'h6, 1,  0,  0,  0,  0,  1,  0);
    vecs[17] = mk(0, 4'h0, 1,  1,  0,  0,  0,  0,  1);
    vecs[18] = mk(1, 4'hF, 0,  1,  1,  1,  0,  0,  1);
    vecs[19] = mk(1, 4'hF, 0,  1,  1,  1,  0,  0,  1);
    vecs[20] = mk(0, 4'h0, 1,  1,  1,  1,  0,  0,  1);
    vecs[21] = mk(0, 4'h0, 1,  1,  1,  1,  0,  0,  1);
    vecs[22] = mk(0, 4'h0, 0,  1,  0,  0,  1,  0,  1);
    vecs[23] = mk(0, 4'h0, 1,  1,  0,  0,  1,  1,  1);
    vecs[24] = mk(0, 4'h0, 1,  0,  0,  0,  0,  1,  0);
    // data toggling without valid must not start a word
    vecs[25] = mk(0, 4'hC, 1,  0,  0,  0,  0,  1,  0);
    vecs[26] = mk(0, 4'h3, 1,  0,  0,  0,  0,  1,  0);

    // 4'h3 after an aborted word
    post[0] = mk(1, 4'h3, 1,  0,  0,  0,  0,  1,  0);
    post[1] = mk(0, 4'h0, 1,  1,  0,  1,  0,  0,  1);
    post[2] = mk(0, 4'h0, 1,  1,  0,  1,  0,  0,  1);
    post[3] = mk(0, 4'h0, 1,  1,  1,  0,  0,  0,  1);
    post[4] = mk(0, 4'h0, 1,  1,  1,  0,  1,  1,  1);
    post[5] = mk(0, 4'h0, 1,  0,  0,  0,  0,  1,  0);

    // Reset state while rst is held
    #13;
    chk("rst so_valid", sv_m, 1'b0);
    chk("rst so_last",  last_m, 1'b0);
    chk("rst busy",     busy_m, 1'b0);
    chk("rst so",       so_m, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst pi_ready", pr_m, 1'b1);

    for (int i = 0; i < 27; i++) begin
      step(vecs[i], i);
    end

    // Abort: 4'hF, reset asynchronously after two bits, then 4'h3
    @(posedge clk); #2; pi_valid = 1'b1; pi_data = 4'hF; so_ready = 1'b1;
    @(posedge clk); #2; pi_valid = 1'b0;
    #1;
    chk("abort bit1 valid", sv_m, 1'b1);
    chk("abort bit1 so",    so_m, 1'b1);
    @(posedge clk); #2;
    #1;
    chk("abort bit2 valid", sv_m, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort async so_valid", sv_m, 1'b0);
    chk("abort async so_last",  last_m, 1'b0);
    chk("abort async busy",     busy_m, 1'b0);
    chk("abort async lsb_valid", sv_l, 1'b0);
    chk("abort async so",       so_m, 1'b0);
    @(posedge clk); #2;
    chk("abort held so_valid", sv_m, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort pi_ready", pr_m, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(post[i], 100 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
